// File: rtl/demux_dest_if.sv
// Word/handshake bundle between the VC mux output, demux_dest and the two destination consumers.
// Carries drop_count only when DEMUX_DROP_CNT_EN is defined.
interface demux_dest_if #(
  parameter int BITNUMBER = 5
);
  logic [BITNUMBER-1:0] data_in;
  logic                 valid_in;
  logic                 pop0;
  logic                 pop1;
  logic [BITNUMBER-1:0] data_out0;
  logic [BITNUMBER-1:0] data_out1;
  logic                 valid_out0;
  logic                 valid_out1;
  logic                 full0;
  logic                 full1;
  logic                 empty0;
  logic                 empty1;
  logic                 almost_full0;
  logic                 almost_full1;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]           drop_count;

  modport master (
    output data_in, valid_in, pop0, pop1,
    input  data_out0, data_out1, valid_out0, valid_out1,
    input  full0, full1, empty0, empty1, almost_full0, almost_full1,
    input  drop_count
  );

  modport slave (
    input  data_in, valid_in, pop0, pop1,
    output data_out0, data_out1, valid_out0, valid_out1,
    output full0, full1, empty0, empty1, almost_full0, almost_full1,
    output drop_count
  );
`else
  modport master (
    output data_in, valid_in, pop0, pop1,
    input  data_out0, data_out1, valid_out0, valid_out1,
    input  full0, full1, empty0, empty1, almost_full0, almost_full1
  );

  modport slave (
    input  data_in, valid_in, pop0, pop1,
    output data_out0, data_out1, valid_out0, valid_out1,
    output full0, full1, empty0, empty1, almost_full0, almost_full1
  );
`endif
endinterface

// File: rtl/demux_dest.sv
// Steers each valid word by its MSB into one of two small FIFOs with registered pop output.
// Optional feature: define DEMUX_DROP_CNT_EN to add a saturating overflow-drop counter (drop_count).
module demux_dest #(
  parameter int BITNUMBER = 5,
  parameter int DEPTH     = 4,
  parameter int PTRW      = 2
) (
  input  logic          clk,
  input  logic          reset,
  demux_dest_if.slave   bus
);
  localparam int NDEST = 2;
  localparam logic [PTRW:0] FULL_CNT  = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] AFULL_CNT = (PTRW+1)'(DEPTH - 1);

  logic             dest_sel;
  logic [NDEST-1:0] pop_req;
  logic [NDEST-1:0] push_en;
  logic [NDEST-1:0] pop_en;
  logic [NDEST-1:0] full_w;
  logic [NDEST-1:0] empty_w;
  logic [NDEST-1:0] afull_w;
`ifdef DEMUX_DROP_CNT_EN
  logic [NDEST-1:0] drop_hit;
`endif

  assign dest_sel = bus.data_in[BITNUMBER-1];
  assign pop_req  = {bus.pop1, bus.pop0};

  generate
    for (genvar gi = 0; gi < NDEST; gi++) begin : g_fifo
      logic [BITNUMBER-1:0] mem [DEPTH];
      logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
      logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
      logic [PTRW:0]        count_q,  count_d;
      logic [BITNUMBER-1:0] dout_q;
      logic                 vout_q;
      logic                 sel;

      assign sel          = bus.valid_in && (dest_sel == 1'(gi));
      assign full_w[gi]   = (count_q == FULL_CNT);
      assign empty_w[gi]  = (count_q == '0);
      assign afull_w[gi]  = (count_q >= AFULL_CNT);
      assign pop_en[gi]   = pop_req[gi] && !empty_w[gi];
      // A pop on a full FIFO frees the slot in the same edge, so the push still lands.
      assign push_en[gi]  = sel && (!full_w[gi] || pop_en[gi]);
`ifdef DEMUX_DROP_CNT_EN
      assign drop_hit[gi] = sel && full_w[gi] && !pop_en[gi];
`endif

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en[gi]) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en[gi]) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en[gi], pop_en[gi]})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (push_en[gi]) begin
          mem[wr_ptr_q] <= bus.data_in;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
          dout_q   <= '0;
          vout_q   <= 1'b0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
          vout_q   <= pop_en[gi];
          // Read-before-write: on full push+pop the old word at rd_ptr is returned.
          if (pop_en[gi]) begin
            dout_q <= mem[rd_ptr_q];
          end
        end
      end
    end
  endgenerate

  assign bus.data_out0    = g_fifo[0].dout_q;
  assign bus.data_out1    = g_fifo[1].dout_q;
  assign bus.valid_out0   = g_fifo[0].vout_q;
  assign bus.valid_out1   = g_fifo[1].vout_q;
  assign bus.full0        = full_w[0];
  assign bus.full1        = full_w[1];
  assign bus.empty0       = empty_w[0];
  assign bus.empty1       = empty_w[1];
  assign bus.almost_full0 = afull_w[0];
  assign bus.almost_full1 = afull_w[1];

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((|drop_hit) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_demux_dest.sv
// Directed bench for demux_dest: queue-based reference model checked every cycle,
// plus literal expectations from the test plan.
module tb_demux_dest;
  logic clk;
  logic reset;

  demux_dest_if #(.BITNUMBER(5)) bus ();

  demux_dest #(.BITNUMBER(5), .DEPTH(4), .PTRW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: two plain queues, pop applied before push each edge.
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [4:0] ed0, ed1;
  logic       ev0, ev1;
  int         edrop;
  bit         model_on = 0;

  always @(posedge clk) begin
    if (!reset) begin
      q0.delete(); q1.delete();
      ed0 = 0; ed1 = 0; ev0 = 0; ev1 = 0; edrop = 0;
      model_on = 1;
    end else begin
      ev0 = 0;
      ev1 = 0;
      if (bus.pop0 && q0.size() > 0) begin ed0 = q0.pop_front(); ev0 = 1; end
      if (bus.pop1 && q1.size() > 0) begin ed1 = q1.pop_front(); ev1 = 1; end
      if (bus.valid_in) begin
        if (!bus.data_in[4]) begin
          if (q0.size() < 4) q0.push_back(bus.data_in);
          else if (edrop < 255) edrop++;
        end else begin
          if (q1.size() < 4) q1.push_back(bus.data_in);
          else if (edrop < 255) edrop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_dout0",  32'(bus.data_out0),    32'(ed0));
      check("m_dout1",  32'(bus.data_out1),    32'(ed1));
      check("m_vout0",  32'(bus.valid_out0),   32'(ev0));
      check("m_vout1",  32'(bus.valid_out1),   32'(ev1));
      check("m_full0",  32'(bus.full0),        32'(q0.size() == 4));
      check("m_full1",  32'(bus.full1),        32'(q1.size() == 4));
      check("m_empty0", 32'(bus.empty0),       32'(q0.size() == 0));
      check("m_empty1", 32'(bus.empty1),       32'(q1.size() == 0));
      check("m_afull0", 32'(bus.almost_full0), 32'(q0.size() >= 3));
      check("m_afull1", 32'(bus.almost_full1), 32'(q1.size() >= 3));
`ifdef DEMUX_DROP_CNT_EN
      check("m_drops",  32'(bus.drop_count),   32'(edrop));
`endif
    end
  end

  task automatic step(input logic v, input logic [4:0] d, input logic p0, input logic p1);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.pop0     = p0;
    bus.pop1     = p1;
    @(posedge clk);
    #1;
    bus.valid_in = 0;
    bus.pop0     = 0;
    bus.pop1     = 0;
    $display("txn rst=%0b v=%0b d=%h pop0=%0b pop1=%0b -> out0=%h/%0b out1=%h/%0b e0=%0b e1=%0b f0=%0b",
             reset, v, d, p0, p1, bus.data_out0, bus.valid_out0, bus.data_out1, bus.valid_out1,
             bus.empty0, bus.empty1, bus.full0);
  endtask

  initial begin
    clk = 0;
    reset = 0;
    bus.valid_in = 0;
    bus.data_in  = 0;
    bus.pop0 = 0;
    bus.pop1 = 0;

    // Reset and idle
    step(0, 5'h00, 0, 0);
    step(0, 5'h00, 0, 0);
    reset = 1;
    step(0, 5'h00, 0, 0);
    check("rst_dout0",  32'(bus.data_out0),  32'h0);
    check("rst_dout1",  32'(bus.data_out1),  32'h0);
    check("rst_vout0",  32'(bus.valid_out0), 32'h0);
    check("rst_vout1",  32'(bus.valid_out1), 32'h0);
    check("rst_empty0", 32'(bus.empty0),     32'h1);
    check("rst_empty1", 32'(bus.empty1),     32'h1);
    check("rst_full0",  32'(bus.full0),      32'h0);
    check("rst_afull1", 32'(bus.almost_full1), 32'h0);

    // Routing
    step(1, 5'h05, 0, 0);
    step(1, 5'h17, 0, 0);
    check("route_empty0", 32'(bus.empty0), 32'h0);
    check("route_empty1", 32'(bus.empty1), 32'h0);
    step(0, 5'h00, 1, 1);
    check("route_dout0", 32'(bus.data_out0),  32'h05);
    check("route_dout1", 32'(bus.data_out1),  32'h17);
    check("route_vout0", 32'(bus.valid_out0), 32'h1);
    check("route_vout1", 32'(bus.valid_out1), 32'h1);
    step(0, 5'h00, 0, 0);
    check("route_vdrop", 32'(bus.valid_out0), 32'h0);
    check("route_hold",  32'(bus.data_out0),  32'h05);

    // Fill and overflow
    step(1, 5'h01, 0, 0);
    step(1, 5'h02, 0, 0);
    step(1, 5'h03, 0, 0);
    check("fill_afull3", 32'(bus.almost_full0), 32'h1);
    check("fill_full3",  32'(bus.full0),        32'h0);
    step(1, 5'h04, 0, 0);
    check("fill_full4",  32'(bus.full0),        32'h1);
    step(1, 5'h0F, 0, 0);
    check("ovf_full",    32'(bus.full0),        32'h1);
`ifdef DEMUX_DROP_CNT_EN
    check("ovf_drops",   32'(bus.drop_count),   32'h1);
`endif

    // Full push+pop
    step(1, 5'h0A, 1, 0);
    check("fpp_dout0", 32'(bus.data_out0), 32'h01);
    check("fpp_full0", 32'(bus.full0),     32'h1);
    step(0, 5'h00, 1, 0);
    check("drain_02", 32'(bus.data_out0), 32'h02);
    step(0, 5'h00, 1, 0);
    check("drain_03", 32'(bus.data_out0), 32'h03);
    step(0, 5'h00, 1, 0);
    check("drain_04", 32'(bus.data_out0), 32'h04);
    step(0, 5'h00, 1, 0);
    check("drain_0A", 32'(bus.data_out0), 32'h0A);
    check("drain_empty0", 32'(bus.empty0), 32'h1);
    step(0, 5'h00, 1, 0);
    check("udf0_vout", 32'(bus.valid_out0), 32'h0);
    check("udf0_hold", 32'(bus.data_out0),  32'h0A);

    // Empty push+pop and underflow on FIFO1
    step(1, 5'h18, 0, 1);
    check("epp_vout1",  32'(bus.valid_out1), 32'h0);
    check("epp_empty1", 32'(bus.empty1),     32'h0);
    step(0, 5'h00, 0, 1);
    check("epp_dout1",  32'(bus.data_out1),  32'h18);
    check("epp_vout1b", 32'(bus.valid_out1), 32'h1);
    step(0, 5'h00, 0, 1);
    check("udf1_vout",  32'(bus.valid_out1), 32'h0);
    check("udf1_empty", 32'(bus.empty1),     32'h1);

    // Cross-FIFO push and pop in the same cycle
    step(1, 5'h07, 0, 0);
    step(1, 5'h1C, 1, 0);
    check("cross_dout0", 32'(bus.data_out0), 32'h07);
    check("cross_empty1", 32'(bus.empty1),   32'h0);
    step(0, 5'h00, 0, 1);
    check("cross_dout1", 32'(bus.data_out1), 32'h1C);

    // Mid-operation reset
    step(1, 5'h01, 0, 0);
    step(1, 5'h02, 0, 0);
    step(1, 5'h11, 0, 0);
    step(1, 5'h12, 0, 0);
    reset = 0;
    step(1, 5'h03, 1, 1);
    reset = 1;
    check("mrst_empty0", 32'(bus.empty0),     32'h1);
    check("mrst_empty1", 32'(bus.empty1),     32'h1);
    check("mrst_vout0",  32'(bus.valid_out0), 32'h0);
    check("mrst_dout1",  32'(bus.data_out1),  32'h0);
`ifdef DEMUX_DROP_CNT_EN
    check("mrst_drops",  32'(bus.drop_count), 32'h0);
`endif
    step(0, 5'h00, 1, 1);
    check("mrst_pop0", 32'(bus.valid_out0), 32'h0);
    check("mrst_pop1", 32'(bus.valid_out1), 32'h0);
    step(0, 5'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_dest.md
# demux_dest

Destination-side demultiplexer for the virtual-channel link: accepts the single serialized word stream produced by the VC0/VC1 mux and steers each valid word into one of two destination FIFOs. It is selected by the word's MSB (destination bit). Each destination has a 4-entry buffer with full/empty/almost-full flags and a registered pop-side output. The block sits at the receiving end of the link, between the mux output (`data_out_dest`/`valid_out_dest`) and the two destination consumers.

## Interface
Parameters:
- `BITNUMBER`, 5: word width; bit `BITNUMBER-1` is the destination bit.
- `DEPTH`, 4: entries per destination FIFO; power of two, minimum 2.
- `PTRW`, 2: pointer width, equal to log2(`DEPTH`).

Ports:
- `clk`, input, 1: single clock; all logic updates on its rising edge.
- `reset`, input, 1: synchronous, active-low; 0 sampled at `posedge clk` clears the block.
- `data_in`, input, `BITNUMBER`: word from the mux output.
- `valid_in`, input, 1: `data_in` is valid this cycle.
- `pop0`, `pop1`, input, 1 each: consumer read request for destination 0 or 1.
- `data_out0`, `data_out1`, output reg, `BITNUMBER` each: registered read data.
- `valid_out0`, `valid_out1`, output reg, 1 each: `data_out*` holds a word popped last cycle.
- `full0`, `full1`, output, 1 each: FIFO holds `DEPTH` words.
- `empty0`, `empty1`, output, 1 each: FIFO holds 0 words.
- `almost_full0`, `almost_full1`, output, 1 each: FIFO holds at least `DEPTH-1` words; the upstream pause hint.

## Operation
- Routing: `dest = data_in[BITNUMBER-1]`.
  - `dest = 0` writes FIFO0; `dest = 1` writes FIFO1.
  - The full word, including the destination bit, is stored unmodified.
- Push: when `valid_in = 1` and the selected FIFO is not full, the word is written at `wr_ptr`, then `wr_ptr` and `count` are incremented.
- Overflow: when `valid_in = 1` and the selected FIFO is full with no same-cycle pop, the word is dropped. Pointers and `count` are unchanged.
- Pop: when `pop_i = 1` and FIFO_i is not empty, `mem[rd_ptr]` is registered into `data_out_i`, `valid_out_i = 1`, `rd_ptr` is incremented and `count` is decremented.
- Underflow: when `pop_i = 1` and FIFO_i is empty, the pop is ignored.
  - `valid_out_i = 0`; `data_out_i` holds its previous value.
- Simultaneous push and pop on the same FIFO:
  - Full: both are performed and `count` is unchanged; the pop frees the slot in the same edge.
  - Empty: the push is performed and the pop is ignored (no fall-through); `valid_out_i = 0`.
  - Otherwise: both are performed and `count` is unchanged.
- FIFO0 and FIFO1 are independent. A push to one and a pop from the other in the same cycle are both honored.
- Pointers wrap modulo `DEPTH`. `count` is `PTRW+1` bits wide, range 0..`DEPTH`.
- Flags are combinational from `count`: `full = (count == DEPTH)`, `empty = (count == 0)`, `almost_full = (count >= DEPTH-1)`.
- Reset: `wr_ptr`, `rd_ptr`, `count` = 0; `data_out*` = 0; `valid_out*` = 0.
  - Flags after reset: `empty* = 1`, `full* = 0`, `almost_full* = 0`.
  - Memory contents are don't-care.
  - A reset mid-operation discards all buffered words. Inputs in the reset cycle are ignored.

## Timing
- Write latency: a word pushed at edge N is poppable at edge N+1 (`empty` deasserts after edge N).
- Read latency: a pop sampled at edge N gives `data_out`/`valid_out` valid after edge N, for one cycle. `valid_out` drops the next cycle unless the pop is repeated.
- Back-to-back pops stream one word per cycle.
- Flags reflect the state after the most recent edge.
- Upstream must stop `valid_in` for a destination whose `almost_full` is asserted, or accept drops.

## Configuration
- `DEMUX_DROP_CNT_EN`, defined: adds output `drop_count` [7:0].
  - Increments by 1 on each overflow drop, counting both FIFOs combined.
  - Saturates at 255; reset to 0 by `reset`.
- `DEMUX_DROP_CNT_EN`, undefined: the port and counter are absent. Drops are silent, with otherwise identical behaviour.

## Test plan
- Reset and idle: hold `reset = 0` for 2 cycles, then release with no traffic.
  - Required: all `data_out` = 0, `valid_out` = 0, `empty0 = empty1 = 1`, `full` = 0.
- Routing: push 5'h05, then 5'h17.
  - Required: FIFO0 count 1, FIFO1 count 1.
  - Then pulse `pop0` and `pop1`: next cycle `data_out0 = 5'h05`, `data_out1 = 5'h17`, both `valid_out` = 1.
- Fill and overflow: push 5'h01, 02, 03, 04, then 5'h0F, all to dest 0.
  - Required: `almost_full0` after the 3rd push, `full0` after the 4th, 5'h0F dropped.
  - Draining yields 01, 02, 03, 04; with the macro defined, `drop_count = 1`.
- Full push+pop: with FIFO0 full, push 5'h0A and pop in the same cycle.
  - Required: `data_out0 = 5'h01`, `full0` stays 1, and the last word drained is 5'h0A.
- Empty push+pop and underflow: with FIFO1 empty, push 5'h18 and pop in the same cycle.
  - Required: `valid_out1 = 0`, count becomes 1.
  - Popping again gives 5'h18; a further pop while empty gives `valid_out1 = 0`.
- Mid-operation reset: with 2 words in each FIFO, assert `reset` for 1 cycle.
  - Required: `empty0 = empty1 = 1`, `valid_out` = 0, and the next pop returns no data.
